// File: rtl/controlador_mapa.sv
// controlador_mapa: validates/clamps sensor samples, queues them, issues them one at a time to the mapper.
// Latency: accept-to-mapaNovoDado 2 cycles; backpressure via amostraPronta when the queue is full.
module controlador_mapa #(
  parameter int TamanhoMalha     = 20,
  parameter int tamanhoDistancia = 8,
  parameter int ProfundidadeFila = 4,
  parameter int LimiteTimeout    = 1023
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  amostraValida,
  output logic                                  amostraPronta,
  input  logic [tamanhoDistancia-1:0]           posX,
  input  logic [tamanhoDistancia-1:0]           posY,
  input  logic                                  direcao,
  input  logic [tamanhoDistancia-1:0]           distFrente,
  input  logic [tamanhoDistancia-1:0]           distDireita,
  input  logic [tamanhoDistancia-1:0]           distEsquerda,
  output logic                                  mapaNovoDado,
  output logic [tamanhoDistancia-1:0]           mapaX,
  output logic [tamanhoDistancia-1:0]           mapaY,
  output logic                                  mapaDirecao,
  output logic [tamanhoDistancia-1:0]           mapaFrente,
  output logic [tamanhoDistancia-1:0]           mapaDireita,
  output logic [tamanhoDistancia-1:0]           mapaEsquerda,
  input  logic                                  mapaFinalizada,
  output logic [$clog2(ProfundidadeFila+1)-1:0] ocupacaoFila,
  output logic [7:0]                            descartes,
  output logic                                  erroTimeout,
  input  logic                                  limparErro
);
  localparam int W  = tamanhoDistancia;
  localparam int PW = $clog2(ProfundidadeFila);
  localparam int CW = $clog2(ProfundidadeFila + 1);
  localparam int TW = $clog2(LimiteTimeout + 1);
  localparam logic [W-1:0]  MALHA      = W'(TamanhoMalha);
  localparam logic [W-1:0]  MAX_COORD  = W'(TamanhoMalha - 1);
  localparam logic [CW-1:0] CHEIA      = CW'(ProfundidadeFila);
  localparam logic [TW-1:0] LIMITE_FIM = TW'(LimiteTimeout - 1);

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         dir;
    logic [W-1:0] frente;
    logic [W-1:0] direita;
    logic [W-1:0] esquerda;
  } amostra_t;

  typedef enum logic [1:0] {IDLE, EMITIR, AGUARDAR_INICIO, AGUARDAR_FIM} estado_t;

  estado_t        estado_q, estado_d;
  amostra_t       fila_q [ProfundidadeFila];
  amostra_t       entrada;
  amostra_t       saida_q;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  ocup_q;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [7:0]     descartes_q;
  logic           erro_q, erro_d;
  logic [W-1:0]   lateral, limite_dir;
  logic           aceita, fora, push, pop, timeout;

  assign amostraPronta = (ocup_q != CHEIA);
  assign aceita        = amostraValida && amostraPronta;
  assign fora          = (posX >= MALHA) || (posY >= MALHA);
  assign push          = aceita && !fora;

  // Only evaluated for in-grid samples, so MAX_COORD - lateral cannot underflow.
  always_comb begin
    lateral          = direcao ? posX : posY;
    limite_dir       = MAX_COORD - lateral;
    entrada.x        = posX;
    entrada.y        = posY;
    entrada.dir      = direcao;
    entrada.frente   = distFrente;
    entrada.direita  = (distDireita > limite_dir) ? limite_dir : distDireita;
    entrada.esquerda = (distEsquerda > lateral) ? lateral : distEsquerda;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ocup_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   ocup_q <= ocup_q + CW'(1);
        2'b01:   ocup_q <= ocup_q - CW'(1);
        default: ocup_q <= ocup_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fila_q[wr_ptr_q] <= entrada;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      saida_q     <= '0;
      descartes_q <= '0;
      estado_q    <= IDLE;
      cnt_q       <= '0;
      erro_q      <= 1'b0;
    end else begin
      if (pop) saida_q <= fila_q[rd_ptr_q];
      if (aceita && fora && (descartes_q != 8'hFF)) descartes_q <= descartes_q + 8'd1;
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      erro_q   <= erro_d;
    end
  end

  always_comb begin
    estado_d     = estado_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    timeout      = 1'b0;
    mapaNovoDado = 1'b0;
    case (estado_q)
      IDLE: begin
        if ((ocup_q != '0) && mapaFinalizada && !erro_q) begin
          pop      = 1'b1;
          estado_d = EMITIR;
        end
      end
      EMITIR: begin
        mapaNovoDado = 1'b1;
        cnt_d        = '0;
        estado_d     = AGUARDAR_INICIO;
      end
      AGUARDAR_INICIO: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == LIMITE_FIM) timeout = 1'b1;
        else if (!mapaFinalizada) estado_d = AGUARDAR_FIM;
      end
      AGUARDAR_FIM: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == LIMITE_FIM) timeout = 1'b1;
        else if (mapaFinalizada) estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
    if (timeout) estado_d = IDLE;
  end

  // A timeout coinciding with a clear request leaves the flag set.
  always_comb begin
    erro_d = erro_q;
    if (limparErro) erro_d = 1'b0;
    if (timeout)    erro_d = 1'b1;
  end

  assign mapaX        = saida_q.x;
  assign mapaY        = saida_q.y;
  assign mapaDirecao  = saida_q.dir;
  assign mapaFrente   = saida_q.frente;
  assign mapaDireita  = saida_q.direita;
  assign mapaEsquerda = saida_q.esquerda;
  assign ocupacaoFila = ocup_q;
  assign descartes    = descartes_q;
  assign erroTimeout  = erro_q;
endmodule

// File: tb/tb_controlador_mapa.sv
// Directed bench for controlador_mapa with a simple busy-cycle mapper model.
module tb_controlador_mapa;
  logic       clock = 1'b0;
  logic       reset;
  logic       amostraValida;
  logic       amostraPronta;
  logic [7:0] posX, posY;
  logic       direcao;
  logic [7:0] distFrente, distDireita, distEsquerda;
  logic       mapaNovoDado;
  logic [7:0] mapaX, mapaY, mapaFrente, mapaDireita, mapaEsquerda;
  logic       mapaDirecao;
  logic       mapaFinalizada;
  logic [2:0] ocupacaoFila;
  logic [7:0] descartes;
  logic       erroTimeout;
  logic       limparErro;

  int vetores = 0;
  int miscompares = 0;

  logic [7:0] rec_x[$], rec_y[$], rec_dd[$], rec_de[$];
  int   ciclos_ocupado = 3;
  int   ocupado_rest = 0;
  logic segurar = 1'b0;
  logic cancelar = 1'b0;

  always #5 clock = ~clock;

  controlador_mapa dut (
    .clock(clock), .reset(reset),
    .amostraValida(amostraValida), .amostraPronta(amostraPronta),
    .posX(posX), .posY(posY), .direcao(direcao),
    .distFrente(distFrente), .distDireita(distDireita), .distEsquerda(distEsquerda),
    .mapaNovoDado(mapaNovoDado), .mapaX(mapaX), .mapaY(mapaY), .mapaDirecao(mapaDirecao),
    .mapaFrente(mapaFrente), .mapaDireita(mapaDireita), .mapaEsquerda(mapaEsquerda),
    .mapaFinalizada(mapaFinalizada), .ocupacaoFila(ocupacaoFila), .descartes(descartes),
    .erroTimeout(erroTimeout), .limparErro(limparErro)
  );

  // Mapper model: goes busy for ciclos_ocupado cycles after each start pulse.
  initial begin
    mapaFinalizada = 1'b1;
    forever begin
      @(negedge clock);
      if (mapaNovoDado === 1'b1) begin
        rec_x.push_back(mapaX);
        rec_y.push_back(mapaY);
        rec_dd.push_back(mapaDireita);
        rec_de.push_back(mapaEsquerda);
        ocupado_rest = ciclos_ocupado;
      end else if (cancelar) begin
        ocupado_rest = 0;
      end else if (ocupado_rest > 0) begin
        ocupado_rest = ocupado_rest - 1;
      end
      mapaFinalizada = !(segurar || (ocupado_rest > 0));
    end
  end

  task automatic aplicar_reset();
    reset = 1'b1;
    amostraValida = 1'b0;
    limparErro = 1'b0;
    segurar = 1'b0;
    cancelar = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cancelar = 1'b0;
    rec_x.delete(); rec_y.delete(); rec_dd.delete(); rec_de.delete();
  endtask

  task automatic enviar(input logic [7:0] x, input logic [7:0] y, input logic d,
                        input logic [7:0] f, input logic [7:0] dd, input logic [7:0] de);
    int espera = 0;
    posX = x; posY = y; direcao = d;
    distFrente = f; distDireita = dd; distEsquerda = de;
    amostraValida = 1'b1;
    while (amostraPronta !== 1'b1 && espera < 200) begin
      @(negedge clock);
      espera++;
    end
    if (espera >= 200) begin
      vetores++; miscompares++;
      $display("FAIL enviar_timeout: amostraPronta=%b never 1 within 200 cycles", amostraPronta);
    end
    @(negedge clock);
    amostraValida = 1'b0;
  endtask

  task automatic esperar_pulsos(input int n);
    int k = 0;
    while (rec_x.size() < n && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (rec_x.size() < n) begin
      vetores++; miscompares++;
      $display("FAIL esperar_pulsos: got %0d pulses, need %0d", rec_x.size(), n);
    end
  endtask

  task automatic test_reset();
    aplicar_reset();
    vetores++;
    if (ocupacaoFila !== 3'd0 || amostraPronta !== 1'b1 || mapaNovoDado !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_fila: ocup=%0d pronto=%b novo=%b, need 0 1 0", ocupacaoFila, amostraPronta, mapaNovoDado);
    end
    vetores++;
    if (descartes !== 8'd0 || erroTimeout !== 1'b0 || mapaX !== 8'd0 || mapaDireita !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_regs: desc=%0d erro=%b X=%0d D=%0d, need 0 0 0 0", descartes, erroTimeout, mapaX, mapaDireita);
    end
  endtask

  task automatic test_amostra_unica();
    aplicar_reset();
    ciclos_ocupado = 6;
    posX = 8'd5; posY = 8'd7; direcao = 1'b1;
    distFrente = 8'd4; distDireita = 8'd3; distEsquerda = 8'd2;
    amostraValida = 1'b1;
    @(negedge clock);
    amostraValida = 1'b0;
    vetores++;
    if (mapaNovoDado !== 1'b0 || ocupacaoFila !== 3'd1) begin
      miscompares++;
      $display("FAIL unica_aceite: novo=%b ocup=%0d, need 0 1", mapaNovoDado, ocupacaoFila);
    end
    @(negedge clock);
    vetores++;
    if (mapaNovoDado !== 1'b1 || ocupacaoFila !== 3'd0) begin
      miscompares++;
      $display("FAIL unica_pulso: novo=%b ocup=%0d, need 1 0", mapaNovoDado, ocupacaoFila);
    end
    vetores++;
    if (mapaX !== 8'd5 || mapaY !== 8'd7 || mapaDirecao !== 1'b1 || mapaFrente !== 8'd4 ||
        mapaDireita !== 8'd3 || mapaEsquerda !== 8'd2) begin
      miscompares++;
      $display("FAIL unica_dados: X=%0d Y=%0d dir=%b F=%0d D=%0d E=%0d, need 5 7 1 4 3 2",
               mapaX, mapaY, mapaDirecao, mapaFrente, mapaDireita, mapaEsquerda);
    end
    @(negedge clock);
    vetores++;
    if (mapaNovoDado !== 1'b0 || mapaX !== 8'd5) begin
      miscompares++;
      $display("FAIL unica_pulso_unico: novo=%b X=%0d, need 0 5", mapaNovoDado, mapaX);
    end
    repeat (12) @(negedge clock);
    vetores++;
    if (dut.estado_q !== 2'd0 || rec_x.size() != 1) begin
      miscompares++;
      $display("FAIL unica_fim: estado=%0d pulsos=%0d, need 0 1", dut.estado_q, rec_x.size());
    end
  endtask

  task automatic test_clamp();
    aplicar_reset();
    ciclos_ocupado = 3;
    enviar(8'd18, 8'd3, 1'b1, 8'd7, 8'd9, 8'd25);
    esperar_pulsos(1);
    vetores++;
    if (rec_dd[0] !== 8'd1 || rec_de[0] !== 8'd18) begin
      miscompares++;
      $display("FAIL clamp_vertical: D=%0d E=%0d, need 1 18", rec_dd[0], rec_de[0]);
    end
    enviar(8'd10, 8'd2, 1'b0, 8'd5, 8'd30, 8'd30);
    esperar_pulsos(2);
    vetores++;
    if (rec_dd[1] !== 8'd17 || rec_de[1] !== 8'd2) begin
      miscompares++;
      $display("FAIL clamp_horizontal: D=%0d E=%0d, need 17 2", rec_dd[1], rec_de[1]);
    end
    enviar(8'd19, 8'd19, 1'b1, 8'd0, 8'd5, 8'd5);
    esperar_pulsos(3);
    vetores++;
    if (rec_dd[2] !== 8'd0 || rec_de[2] !== 8'd5 || descartes !== 8'd0) begin
      miscompares++;
      $display("FAIL clamp_borda: D=%0d E=%0d desc=%0d, need 0 5 0", rec_dd[2], rec_de[2], descartes);
    end
    enviar(8'd4, 8'd20, 1'b1, 8'd1, 8'd1, 8'd1);
    repeat (10) @(negedge clock);
    vetores++;
    if (descartes !== 8'd1 || rec_x.size() != 3 || ocupacaoFila !== 3'd0) begin
      miscompares++;
      $display("FAIL descarte_y20: desc=%0d pulsos=%0d ocup=%0d, need 1 3 0", descartes, rec_x.size(), ocupacaoFila);
    end
    for (int i = 0; i < 256; i++) enviar(8'd200, 8'd1, 1'b0, 8'd0, 8'd0, 8'd0);
    vetores++;
    if (descartes !== 8'd255 || rec_x.size() != 3) begin
      miscompares++;
      $display("FAIL descarte_saturacao: desc=%0d pulsos=%0d, need 255 3", descartes, rec_x.size());
    end
  endtask

  task automatic test_back_to_back();
    aplicar_reset();
    ciclos_ocupado = 3;
    segurar = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 1; i <= 4; i++) enviar(8'(i), 8'(i + 10), 1'b0, 8'd0, 8'd0, 8'd0);
    vetores++;
    if (ocupacaoFila !== 3'd4 || amostraPronta !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_cheia: ocup=%0d pronto=%b, need 4 0", ocupacaoFila, amostraPronta);
    end
    fork
      begin
        enviar(8'd5, 8'd15, 1'b0, 8'd0, 8'd0, 8'd0);
        enviar(8'd6, 8'd16, 1'b0, 8'd0, 8'd0, 8'd0);
      end
      begin
        repeat (5) @(negedge clock);
        vetores++;
        if (ocupacaoFila !== 3'd4 || amostraPronta !== 1'b0 || rec_x.size() != 0) begin
          miscompares++;
          $display("FAIL burst_retido: ocup=%0d pronto=%b pulsos=%0d, need 4 0 0", ocupacaoFila, amostraPronta, rec_x.size());
        end
        segurar = 1'b0;
      end
    join
    esperar_pulsos(6);
    for (int i = 0; i < 6; i++) begin
      vetores++;
      if (i >= rec_x.size() || rec_x[i] !== 8'(i + 1) || rec_y[i] !== 8'(i + 11)) begin
        miscompares++;
        $display("FAIL burst_ordem_%0d: X=%0d Y=%0d, need %0d %0d", i,
                 (i < rec_x.size()) ? rec_x[i] : 8'hFF, (i < rec_y.size()) ? rec_y[i] : 8'hFF, i + 1, i + 11);
      end
    end
  endtask

  task automatic test_timeout();
    int  k;
    logic viu;
    aplicar_reset();
    ciclos_ocupado = 100000;
    enviar(8'd1, 8'd1, 1'b0, 8'd0, 8'd0, 8'd0);
    k = 0;
    while (mapaNovoDado !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    enviar(8'd2, 8'd2, 1'b0, 8'd0, 8'd0, 8'd0);
    repeat (1022) @(negedge clock);
    vetores++;
    if (erroTimeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_cedo: erro=%b after 1022 wait cycles, need 0", erroTimeout);
    end
    limparErro = 1'b1;
    @(negedge clock);
    limparErro = 1'b0;
    vetores++;
    if (erroTimeout !== 1'b1 || ocupacaoFila !== 3'd1) begin
      miscompares++;
      $display("FAIL timeout_set_vence: erro=%b ocup=%0d, need 1 1", erroTimeout, ocupacaoFila);
    end
    cancelar = 1'b1;
    ciclos_ocupado = 3;
    repeat (3) @(negedge clock);
    cancelar = 1'b0;
    viu = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      viu |= mapaNovoDado;
    end
    vetores++;
    if (viu !== 1'b0 || erroTimeout !== 1'b1 || ocupacaoFila !== 3'd1) begin
      miscompares++;
      $display("FAIL timeout_bloqueio: pulso=%b erro=%b ocup=%0d, need 0 1 1", viu, erroTimeout, ocupacaoFila);
    end
    limparErro = 1'b1;
    @(negedge clock);
    limparErro = 1'b0;
    vetores++;
    if (erroTimeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_limpar: erro=%b, need 0", erroTimeout);
    end
    k = 0;
    while (mapaNovoDado !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    vetores++;
    if (mapaNovoDado !== 1'b1 || mapaX !== 8'd2) begin
      miscompares++;
      $display("FAIL timeout_retoma: novo=%b X=%0d, need 1 2", mapaNovoDado, mapaX);
    end
  endtask

  task automatic test_reset_meio();
    logic viu;
    aplicar_reset();
    ciclos_ocupado = 20;
    for (int i = 0; i < 4; i++) enviar(8'(i + 10), 8'd3, 1'b0, 8'd0, 8'd0, 8'd0);
    vetores++;
    if (ocupacaoFila !== 3'd3 || dut.estado_q !== 2'd3) begin
      miscompares++;
      $display("FAIL meio_pre: ocup=%0d estado=%0d, need 3 3", ocupacaoFila, dut.estado_q);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vetores++;
    if (ocupacaoFila !== 3'd0 || amostraPronta !== 1'b1 || mapaX !== 8'd0 || erroTimeout !== 1'b0) begin
      miscompares++;
      $display("FAIL meio_reset: ocup=%0d pronto=%b X=%0d erro=%b, need 0 1 0 0", ocupacaoFila, amostraPronta, mapaX, erroTimeout);
    end
    viu = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      viu |= mapaNovoDado;
    end
    vetores++;
    if (viu !== 1'b0) begin
      miscompares++;
      $display("FAIL meio_sem_pulso: pulso=%b, need 0", viu);
    end
  endtask

  initial begin
    reset = 1'b1;
    amostraValida = 1'b0;
    limparErro = 1'b0;
    posX = '0; posY = '0; direcao = 1'b0;
    distFrente = '0; distDireita = '0; distEsquerda = '0;
    @(negedge clock);
    test_reset();
    test_amostra_unica();
    test_clamp();
    test_back_to_back();
    test_timeout();
    test_reset_meio();
    $display("== %0d vectors applied, %0d miscompares ==", vetores, miscompares);
    $finish;
  end
endmodule

// File: doc/controlador_mapa.md
CONTROLADOR_MAPA -- requirements
Module: controlador_mapa

Interface
REQ-001 SHALL have parameters, one per line:
- TamanhoMalha, 20, grid side length in cells.
- tamanhoDistancia, 8, coordinate/distance width in bits.
- ProfundidadeFila, 4, sample FIFO depth (power of two, >=2).
- LimiteTimeout, 1023, max cycles waited for mapper completion.
REQ-002 SHALL have ports, one per line:
- clock  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- amostraValida  input  1  sensor/odometry sample offered.
- amostraPronta  output  1  FIFO can accept a sample.
- posX, posY  input  tamanhoDistancia  robot cell coordinates.
- direcao  input  1  0 horizontal, 1 vertical.
- distFrente, distDireita, distEsquerda  input  tamanhoDistancia  sensor distances in cells.
- mapaNovoDado  output  1  one-cycle start pulse to mapper.
- mapaX, mapaY, mapaDirecao, mapaFrente, mapaDireita, mapaEsquerda  output  as inputs  sample presented to mapper.
- mapaFinalizada  input  1  mapper idle/done (1 = ready).
- ocupacaoFila  output  $clog2(ProfundidadeFila+1)  queued sample count.
- descartes  output  8  saturating count of rejected samples.
- erroTimeout  output  1  sticky mapper-timeout flag.
- limparErro  input  1  clears erroTimeout.
REQ-003 Clock is one clock named clock; reset is named reset, synchronous, active-high.

Function
REQ-004 Sample accepted when amostraValida && amostraPronta on a rising edge; amostraPronta SHALL equal (ocupacaoFila != ProfundidadeFila), combinational from registered count.
REQ-005 Accepted sample with posX >= TamanhoMalha or posY >= TamanhoMalha SHALL NOT be enqueued; descartes increments, saturating at 255.
REQ-006 Valid sample SHALL be clamped before enqueue on the lateral axis (X when direcao=1, Y when direcao=0), p = that coordinate: distDireita -> min(distDireita, TamanhoMalha-1-p); distEsquerda -> min(distEsquerda, p); distFrente unchanged.
REQ-007 FIFO SHALL be first-in first-out, wrap-around pointers; enqueue and dequeue in the same cycle leave ocupacaoFila unchanged.
REQ-008 FSM states: IDLE, EMITIR, AGUARDAR_INICIO, AGUARDAR_FIM.
REQ-009 IDLE: if FIFO non-empty and mapaFinalizada=1, pop head into mapa* registers, go EMITIR; else stay.
REQ-010 EMITIR: mapaNovoDado=1 for exactly this cycle; go AGUARDAR_INICIO.
REQ-011 AGUARDAR_INICIO: when mapaFinalizada=0 go AGUARDAR_FIM.
REQ-012 AGUARDAR_FIM: when mapaFinalizada=1 go IDLE; next issue no earlier than the cycle after IDLE is re-entered (min 1 idle cycle between samples).
REQ-013 One timeout counter, cleared on entering AGUARDAR_INICIO, counts cycles in AGUARDAR_INICIO and AGUARDAR_FIM; on reaching LimiteTimeout SHALL set erroTimeout and return to IDLE; sample is discarded, not retried.
REQ-014 mapa* data outputs SHALL remain stable from EMITIR until the next pop.
REQ-015 mapaNovoDado SHALL never assert while erroTimeout=1; queue keeps accepting samples until full.
REQ-016 limparErro=1 clears erroTimeout next cycle; if timeout and limparErro coincide, set wins.
REQ-017 Latency: sample accepted into empty FIFO with FSM in IDLE and mapaFinalizada=1 SHALL produce mapaNovoDado 2 cycles after acceptance edge.

Reset
REQ-018 reset=1 on a rising edge SHALL: empty FIFO, ocupacaoFila=0, amostraPronta=1 after reset, state IDLE, mapaNovoDado=0, all mapa* data=0, descartes=0, erroTimeout=0, timeout counter=0.
REQ-019 Reset mid-transaction SHALL abandon the in-flight sample and all queued samples; no mapaNovoDado until a new sample is accepted.

Verification
REQ-020 Single sample posX=5,posY=7,direcao=1,distDireita=3,distEsquerda=2, mapper model 6-cycle busy -> one mapaNovoDado pulse 2 cycles later, mapaX=5, mapaDireita=3, mapaEsquerda=2, FSM back in IDLE after completion.
REQ-021 Clamping: posX=18,direcao=1,distDireita=9,distEsquerda=25 -> mapaDireita=1, mapaEsquerda=18; posY=20 -> not issued, descartes=1.
REQ-022 Burst of 6 samples back-to-back, mapper busy -> amostraPronta low after 4, ocupacaoFila=4, samples 5-6 held by source; all 6 issued in order.
REQ-023 Mapper never raises mapaFinalizada -> erroTimeout=1 after 1023 wait cycles, no further pulses; limparErro then next queued sample issued.
REQ-024 reset asserted during AGUARDAR_FIM with 3 queued -> ocupacaoFila=0, no pulse after reset release.
